// File: rtl/dct_sched_pkg.sv
// Shared types and defaults for the DCT multiply-accumulate sequencer.
package dct_sched_pkg;

  localparam int unsigned N_TAPS_D  = 8;
  localparam int unsigned N_OUT_D   = 8;
  localparam int unsigned MAC_LAT_D = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dct_sched_pipe.sv
// Fixed-depth shift of {valid, coefficient index} that mirrors the MAC pipeline latency.
module dct_sched_pipe #(
  parameter int unsigned Depth = 2,
  parameter int unsigned IdxW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            in_valid,
  input  logic [IdxW-1:0] in_idx,
  output logic            out_valid,
  output logic [IdxW-1:0] out_idx,
  output logic            pend
);

  logic [Depth-1:0] valid_q;
  logic [IdxW-1:0]  idx_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) idx_q[i] <= '0;
    end else if (ena) begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= in_idx;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_idx   = idx_q[Depth-1];

  // Results still travelling behind the output stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < int'(Depth) - 1; i++) pend = pend | valid_q[i];
  end

endmodule

// File: rtl/dct_mac_sched.sv
// Walks the N_OUT x N_TAPS products of one 8-point DCT and flags finished coefficients.
module dct_mac_sched
  import dct_sched_pkg::*;
#(
  parameter int unsigned N_TAPS  = N_TAPS_D,
  parameter int unsigned N_OUT   = N_OUT_D,
  parameter int unsigned MAC_LAT = MAC_LAT_D,
  localparam int unsigned TapW   = idx_width(N_TAPS),
  localparam int unsigned OutW   = idx_width(N_OUT),
  localparam int unsigned AddrW  = idx_width(N_OUT * N_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  output logic             busy,
  output logic [TapW-1:0]  samp_idx,
  output logic [AddrW-1:0] coef_addr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             res_valid,
  output logic [OutW-1:0]  res_idx,
  output logic             done
);

  state_e          state_q;
  logic [TapW-1:0] tap_q;
  logic [OutW-1:0] out_q;

  logic            tap_last;
  logic            out_last;
  logic            issue_last;
  logic [OutW-1:0] issue_idx;
  logic            pipe_valid;
  logic [OutW-1:0] pipe_idx;
  logic            pipe_pend;

  assign tap_last = (tap_q == TapW'(N_TAPS - 1));
  assign out_last = (out_q == OutW'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tap_q   <= '0;
      out_q   <= '0;
    end else if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            tap_q   <= '0;
            out_q   <= '0;
          end
        end
        StRun: begin
          if (tap_last) begin
            tap_q <= '0;
            if (out_last) begin
              out_q   <= '0;
              state_q <= StDrain;
            end else begin
              out_q <= out_q + OutW'(1);
            end
          end else begin
            tap_q <= tap_q + TapW'(1);
          end
        end
        // The final result may sit in the output stage while we leave.
        StDrain: if (!pipe_pend) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    mac_en     = ena & (state_q == StRun);
    mac_clr    = mac_en & (tap_q == '0);
    samp_idx   = tap_q;
    coef_addr  = AddrW'(out_q) * AddrW'(N_TAPS) + AddrW'(tap_q);
    issue_last = mac_en & tap_last;
    issue_idx  = issue_last ? out_q : '0;
    res_valid  = ena & pipe_valid;
    res_idx    = pipe_idx;
    done       = ena & (state_q == StDone);
  end

  dct_sched_pipe #(
    .Depth (MAC_LAT),
    .IdxW  (OutW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (issue_last),
    .in_idx    (issue_idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx),
    .pend      (pipe_pend)
  );

endmodule

// File: tb/tb_dct_mac_sched.sv
// Directed bench for dct_mac_sched; three instances cover MAC_LAT = 2, 4 and 1.
module tb_dct_mac_sched;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ena   = 1'b1;
  logic start = 1'b0;

  logic       busy, mac_clr, mac_en, res_valid, done;
  logic [2:0] samp_idx, res_idx;
  logic [5:0] coef_addr;

  logic       busy4, mac_clr4, mac_en4, res_valid4, done4;
  logic [2:0] samp_idx4, res_idx4;
  logic [5:0] coef_addr4;

  logic       busy1, mac_clr1, mac_en1, res_valid1, done1;
  logic [2:0] samp_idx1, res_idx1;
  logic [5:0] coef_addr1;

  dct_mac_sched dut (
    .clk (clk), .rst (rst), .ena (ena), .start (start), .busy (busy),
    .samp_idx (samp_idx), .coef_addr (coef_addr), .mac_clr (mac_clr), .mac_en (mac_en),
    .res_valid (res_valid), .res_idx (res_idx), .done (done)
  );

  dct_mac_sched #(.MAC_LAT (4)) dut4 (
    .clk (clk), .rst (rst), .ena (ena), .start (start), .busy (busy4),
    .samp_idx (samp_idx4), .coef_addr (coef_addr4), .mac_clr (mac_clr4), .mac_en (mac_en4),
    .res_valid (res_valid4), .res_idx (res_idx4), .done (done4)
  );

  dct_mac_sched #(.MAC_LAT (1)) dut1 (
    .clk (clk), .rst (rst), .ena (ena), .start (start), .busy (busy1),
    .samp_idx (samp_idx1), .coef_addr (coef_addr1), .mac_clr (mac_clr1), .mac_en (mac_en1),
    .res_valid (res_valid1), .res_idx (res_idx1), .done (done1)
  );

  always #5 clk = ~clk;

  int cyc;
  int n_cmp;
  int n_err;
  int samp_bad;
  int addr_q[$];
  int idx_q[$];

  logic [255:0] en_m, clr_m, rv_m, dn_m, busy_m, rv4_m, dn4_m, rv1_m, dn1_m;
  logic [16:0]  out_a [256];
  logic [255:0] mask;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] stride(input int first, input int step, input int count);
    logic [255:0] m = '0;
    for (int i = 0; i < count; i++) begin
      if (first + i * step < 256) m[first + i * step] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [255:0] span(input int first, input int count);
    return stride(first, 1, count);
  endfunction

  function automatic int seq_bad(input int q[$], input int m);
    int b = 0;
    foreach (q[i]) if (q[i] != i % m) b++;
    return b;
  endfunction

  // Sample cycle cyc at the falling edge, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (cyc < 256) begin
      en_m[cyc]   = mac_en;
      clr_m[cyc]  = mac_clr;
      rv_m[cyc]   = res_valid;
      dn_m[cyc]   = done;
      busy_m[cyc] = busy;
      rv4_m[cyc]  = res_valid4;
      dn4_m[cyc]  = done4;
      rv1_m[cyc]  = res_valid1;
      dn1_m[cyc]  = done1;
      out_a[cyc]  = {busy, done, res_valid, res_idx, mac_en, mac_clr, samp_idx, coef_addr};
      if (mac_en) begin
        addr_q.push_back(int'(coef_addr));
        if (samp_idx != coef_addr[2:0]) samp_bad++;
      end
      if (res_valid) idx_q.push_back(int'(res_idx));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_test();
    cyc      = 0;
    samp_bad = 0;
    addr_q.delete();
    idx_q.delete();
    en_m  = '0; clr_m = '0; rv_m  = '0; dn_m  = '0; busy_m = '0;
    rv4_m = '0; dn4_m = '0; rv1_m = '0; dn1_m = '0;
    for (int i = 0; i < 256; i++) out_a[i] = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    start_test();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_val("reset_outputs", 256'(out_a[1]), 256'd0);
    check_val("reset_lat_variants", 256'({rv4_m[1], dn4_m[1], rv1_m[1], dn1_m[1]}), 256'd0);
    rst = 1'b0;
    tick();

    // Basic block
    start_test();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (79) tick();
    check_val("basic_mac_en", en_m, span(1, 64));
    check_val("basic_mac_clr", clr_m, stride(1, 8, 8));
    check_val("basic_res_valid", rv_m, stride(10, 8, 8));
    check_val("basic_done", dn_m, stride(67, 1, 1));
    check_val("basic_busy", busy_m, span(1, 67));
    check_val("basic_addr_count", 256'(addr_q.size()), 256'd64);
    check_val("basic_addr_order", 256'(seq_bad(addr_q, 64)), 256'd0);
    check_val("basic_samp_idx", 256'(samp_bad), 256'd0);
    check_val("basic_idx_count", 256'(idx_q.size()), 256'd8);
    check_val("basic_idx_order", 256'(seq_bad(idx_q, 8)), 256'd0);
    check_val("lat4_res_valid", rv4_m, stride(12, 8, 8));
    check_val("lat4_done", dn4_m, stride(69, 1, 1));
    check_val("lat1_res_valid", rv1_m, stride(9, 8, 8));
    check_val("lat1_done", dn1_m, stride(66, 1, 1));

    // ena stall of 3 cycles at cycle 20
    start_test();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    repeat (57) tick();
    check_val("stall_mac_en", en_m, span(1, 19) | span(23, 45));
    check_val("stall_res_valid", rv_m, stride(10, 8, 2) | stride(29, 8, 6));
    check_val("stall_done", dn_m, stride(70, 1, 1));
    check_val("stall_addr_hold", 256'({out_a[20][5:0], out_a[21][5:0], out_a[22][5:0]}),
              256'({6'd19, 6'd19, 6'd19}));
    check_val("stall_idx_order", 256'(seq_bad(idx_q, 8)), 256'(idx_q.size() != 8));

    // Start while busy is dropped; start at 68 runs a second block
    start_test();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (37) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (71) tick();
    check_val("busy_start_mac_en", en_m, span(1, 64) | span(69, 64));
    check_val("busy_start_done", dn_m, stride(67, 68, 2));

    // Reset mid-block at cycle 40, restart at 45
    start_test();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (74) tick();
    mask = ~span(0, 41);
    check_val("rst_pre_res_valid", rv_m & span(0, 40), stride(10, 8, 4));
    check_val("rst_outputs_zero", 256'(out_a[41]), 256'd0);
    check_val("rst_mac_en", en_m & mask, span(46, 64));
    check_val("rst_res_valid", rv_m & mask, stride(55, 8, 8));
    check_val("rst_done", dn_m & mask, stride(112, 1, 1));
    check_val("rst_busy", busy_m & mask, span(46, 67));

    // start held high: back-to-back blocks at 0, 68, 136
    start_test();
    start = 1'b1;
    repeat (204) tick();
    start = 1'b0;
    repeat (46) tick();
    check_val("b2b_mac_en", en_m, span(1, 64) | span(69, 64) | span(137, 64));
    check_val("b2b_res_valid", rv_m, stride(10, 8, 8) | stride(78, 8, 8) | stride(146, 8, 8));
    check_val("b2b_done", dn_m, stride(67, 68, 3));
    check_val("b2b_busy", busy_m, span(1, 67) | span(69, 67) | span(137, 67));
    check_val("b2b_idx_count", 256'(idx_q.size()), 256'd24);
    check_val("b2b_idx_order", 256'(seq_bad(idx_q, 8)), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct_mac_sched.md
# dct_mac_sched

Sequencer for the shared multiply-accumulate unit inside each DCT unit of the fdct_zigzag path. Given a start pulse, it walks all N_OUT×N_TAPS products of one 8-point DCT: cosine-ROM address, sample select, and MAC clear/enable. It tracks the MAC pipeline latency, including the mult_res register stage, to flag when each accumulated coefficient is valid. It sits between the dct_block control and the dct_unit/macu datapath.

## Interface
- N_TAPS, 8, products accumulated per output coefficient
- N_OUT, 8, output coefficients per block
- MAC_LAT, 2, cycles from a mac_en issue to that product appearing in the accumulator output (mult_res reg + acc reg); legal range 1..4
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global clock enable; low freezes all state
- start  in  1  begin one block; sampled only in IDLE with ena=1
- busy  out  1  high in every state except IDLE
- samp_idx  out  $clog2(N_TAPS)  input sample select = tap counter
- coef_addr  out  $clog2(N_OUT*N_TAPS)  cosine ROM address = out_cnt*N_TAPS + tap_cnt
- mac_clr  out  1  high with mac_en on tap 0: accumulator loads product instead of adding
- mac_en  out  1  issue one product this cycle
- res_valid  out  1  accumulator holds finished coefficient res_idx this cycle
- res_idx  out  $clog2(N_OUT)  coefficient index of the current res_valid
- done  out  1  one-cycle pulse, block complete

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE; all transitions gated by ena=1.
- IDLE→RUN on start. Counters tap_cnt and out_cnt are cleared.
- RUN: each enabled cycle issues one product: mac_en=1, mac_clr=(tap_cnt==0).
  - tap_cnt increments and wraps N_TAPS-1→0.
  - On that wrap, out_cnt increments.
  - After the issue with tap_cnt=N_TAPS-1 and out_cnt=N_OUT-1, go to DRAIN.
- Latency pipe: MAC_LAT-deep shift of {last_tap, out_cnt}, where last_tap=(mac_en & tap_cnt==N_TAPS-1). Its output drives res_valid/res_idx. It advances only when ena=1.
- DRAIN: no issues. Leave for DONE when the pipe is empty after the final res_valid has been emitted.
- DONE: done=1 for one cycle, then IDLE.
- mac_en, mac_clr, res_valid and done are all ANDed with ena, so a frozen cycle never issues or reports anything.
- start while busy is ignored; it is not queued.
- samp_idx and coef_addr are combinational from the counters and hold their values during ena=0.
- rst at any point: the next state is IDLE, counters and pipe are cleared, and in-flight results are discarded with no res_valid or done.
- Reset value of every output is 0.

## Timing
- Counting from cycle 0 = the cycle start is sampled in IDLE, with ena held 1:
  - First mac_en: cycle 1.
  - Last mac_en: cycle N_OUT*N_TAPS (64).
  - res_valid for coefficient k: cycle (k+1)*N_TAPS + MAC_LAT, i.e. 10, 18 … 66 at defaults.
  - done: cycle 64+MAC_LAT+1 = 67.
  - busy: high cycles 1..67.
  - Next start accepted: cycle 68.
- Each cycle with ena=0 stretches every later event by exactly one cycle.
- mac_clr of coefficient k+1 and res_valid of coefficient k can coincide; they are independent.

## Structure
- Package dct_sched_pkg holds:
  - The state enum: IDLE/RUN/DRAIN/DONE.
  - Default constants N_TAPS_D, N_OUT_D, MAC_LAT_D.
  - A width helper function.
- Sub-module dct_sched_pipe: parameterised depth MAC_LAT, with valid and index shift register, ena-gated and sync-cleared by rst.

## Test plan
- Basic block: start at cycle 0, ena=1 → mac_en high cycles 1–64; mac_clr at cycles 1, 9 … 57; coef_addr 0..63 in order; res_valid at 10, 18 … 66 with res_idx 0..7; done at 67.
- ena stall: drop ena for 3 cycles at cycle 20 → no mac_en/res_valid during the stall; coef_addr holds 19; done moves to cycle 70; res_idx sequence unchanged.
- Start while busy: pulse start at cycles 0 and 30 → exactly 64 issues and one done at 67; start at 68 begins a second block cleanly.
- Reset mid-block: rst at cycle 40 → busy=0, mac_en=0, all outputs 0 from cycle 41; no res_valid or done afterwards; a new start at 45 runs a full block.
- Latency parameter: MAC_LAT=4 → res_valid at 12, 20 … 68, done at 69; MAC_LAT=1 → final res_valid at 65, done at 66.
- Back-to-back: start held high continuously → blocks begin at cycles 0, 68, 136; no overlap of res_valid across blocks.
